// File: rtl/alu_issue_ctrl.sv
// Two-stage issue pipeline between an RV32I decoder and an external combinational ALU.
// S1 holds the accepted operation and drives the ALU; S2 registers the ALU response.
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7_b5,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic [31:0] imm,
    input  logic [31:0] pc,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_control,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_branch_taken,
    output logic        out_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_SLL  = 5'b10001;
    localparam logic [4:0] ALU_SLT  = 5'b10100;
    localparam logic [4:0] ALU_SLTU = 5'b10101;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_SRL  = 5'b10110;
    localparam logic [4:0] ALU_SRA  = 5'b10111;
    localparam logic [4:0] ALU_OR   = 5'b00110;
    localparam logic [4:0] ALU_AND  = 5'b00111;

    // Shared OP / OP-IMM funct3 decode; sub_ok is low for OP-IMM where funct3 000 is always ADD.
    function automatic logic [4:0] arith_op(input logic [2:0] f3, input logic f7b5,
                                            input logic sub_ok);
        logic [4:0] op;
        op = ALU_ADD;
        case (f3)
            3'b000:  op = (sub_ok && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic        s1_valid_q;
    logic [6:0]  opcode_q;
    logic [2:0]  funct3_q;
    logic        funct7_b5_q;
    logic [31:0] rs1_q;
    logic [31:0] rs2_q;
    logic [31:0] imm_q;
    logic [31:0] pc_q;

    logic        out_valid_q;
    logic [31:0] out_result_q;
    logic        out_taken_q;
    logic        out_illegal_q;

    logic        accept;
    logic        s2_load;
    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic [4:0]  dec_ctrl;
    logic        dec_branch;
    logic        dec_illegal;
    logic        taken_d;
    logic [31:0] result_d;

    assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready = !s1_valid_q || !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        dec_a       = '0;
        dec_b       = '0;
        dec_ctrl    = ALU_ADD;
        dec_branch  = 1'b0;
        dec_illegal = 1'b0;
        case (opcode_q)
            OPC_OP: begin
                dec_a    = rs1_q;
                dec_b    = rs2_q;
                dec_ctrl = arith_op(funct3_q, funct7_b5_q, 1'b1);
            end
            OPC_OPIMM: begin
                dec_a    = rs1_q;
                dec_b    = imm_q;
                dec_ctrl = arith_op(funct3_q, funct7_b5_q, 1'b0);
            end
            OPC_LUI: begin
                dec_b = imm_q;
            end
            OPC_AUIPC: begin
                dec_a = pc_q;
                dec_b = imm_q;
            end
            OPC_BRANCH: begin
                case (funct3_q)
                    3'b000, 3'b001: begin
                        dec_a      = rs1_q;
                        dec_b      = rs2_q;
                        dec_ctrl   = ALU_SUB;
                        dec_branch = 1'b1;
                    end
                    3'b100, 3'b101: begin
                        dec_a      = rs1_q;
                        dec_b      = rs2_q;
                        dec_ctrl   = ALU_SLT;
                        dec_branch = 1'b1;
                    end
                    3'b110, 3'b111: begin
                        dec_a      = rs1_q;
                        dec_b      = rs2_q;
                        dec_ctrl   = ALU_SLTU;
                        dec_branch = 1'b1;
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    assign alu_a       = dec_a;
    assign alu_b       = dec_b;
    assign alu_control = dec_ctrl;

    // BEQ/BGE are taken on a zero ALU result, BNE/BLT(U) on a non-zero one.
    always_comb begin
        taken_d = 1'b0;
        if (dec_branch) begin
            if (funct3_q[2]) taken_d = funct3_q[0] ? alu_zero : !alu_zero;
            else             taken_d = funct3_q[0] ? !alu_zero : alu_zero;
        end
    end

    assign result_d = dec_illegal ? '0 : alu_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else if (accept) begin
            s1_valid_q <= 1'b1;
        end else if (s2_load) begin
            s1_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            opcode_q    <= opcode;
            funct3_q    <= funct3;
            funct7_b5_q <= funct7_b5;
            rs1_q       <= rs1_val;
            rs2_q       <= rs2_val;
            imm_q       <= imm;
            pc_q        <= pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_taken_q   <= 1'b0;
            out_illegal_q <= 1'b0;
        end else if (s2_load) begin
            out_valid_q   <= 1'b1;
            out_result_q  <= result_d;
            out_taken_q   <= taken_d;
            out_illegal_q <= dec_illegal;
        end else if (out_ready) begin
            out_valid_q   <= 1'b0;
        end
    end

    assign out_valid        = out_valid_q;
    assign out_result       = out_result_q;
    assign out_branch_taken = out_taken_q;
    assign out_illegal      = out_illegal_q;

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 The block SHALL have one clock domain and SHALL use a synchronous, active-high reset.
REQ-002 Port list, one per line, as name  direction  width  meaning:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  upstream operation valid.
- in_ready  output  1  block can accept an operation.
- opcode  input  7  instruction opcode.
- funct3  input  3  instruction funct3.
- funct7_b5  input  1  instruction bit 30.
- rs1_val  input  32  source operand 1.
- rs2_val  input  32  source operand 2.
- imm  input  32  sign-extended immediate.
- pc  input  32  instruction address.
- alu_a  output  32  ALU operand a.
- alu_b  output  32  ALU operand b.
- alu_control  output  5  ALU operation select.
- alu_result  input  32  ALU result, combinational from alu_a/alu_b/alu_control.
- alu_zero  input  1  ALU zero flag.
- out_valid  output  1  registered result valid.
- out_ready  input  1  downstream accepts the result.
- out_result  output  32  registered ALU result.
- out_branch_taken  output  1  branch condition true (BRANCH only).
- out_illegal  output  1  unsupported encoding.

Function
REQ-003 Stage S1 SHALL capture opcode, funct3, funct7_b5, rs1_val, rs2_val, imm and pc on any edge where in_valid && in_ready.
- S1 also holds a valid flag, s1_valid.
REQ-004 alu_a, alu_b and alu_control SHALL be driven combinationally from the S1 register only, never from the in_* ports.
REQ-005 ALU codes SHALL be: ADD 00000, SUB 00001, SLL 10001, SLT 10100, SLTU 10101, XOR 00100, SRL 10110, SRA 10111, OR 00110, AND 00111.
REQ-006 OP (0110011) SHALL map as follows:
- a = rs1, b = rs2.
- funct3 000: ADD if funct7_b5=0, SUB if funct7_b5=1.
- funct3 001: SLL. 010: SLT. 011: SLTU. 100: XOR.
- funct3 101: SRL if funct7_b5=0, SRA if funct7_b5=1.
- funct3 110: OR. 111: AND.
REQ-007 OP-IMM (0010011) SHALL map as OP with b = imm, except:
- funct3 000 is always ADD (funct7_b5 ignored).
- funct3 101 uses funct7_b5 to select SRL or SRA.
REQ-008 LUI (0110111) SHALL use a = 0, b = imm, ADD.
REQ-009 AUIPC (0010111) SHALL use a = pc, b = imm, ADD.
REQ-010 BRANCH (1100011) SHALL use a = rs1, b = rs2, with:
- funct3 000/001 (BEQ/BNE): SUB; taken = alu_zero for BEQ, !alu_zero for BNE.
- funct3 100/101 (BLT/BGE): SLT; taken = !alu_zero for BLT, alu_zero for BGE.
- funct3 110/111 (BLTU/BGEU): SLTU; same polarity as BLT/BGE.
REQ-011 Any other opcode, or BRANCH funct3 010/011, SHALL be illegal:
- alu_control = ADD, alu_a = 0, alu_b = 0.
- out_illegal = 1, out_result = 0, out_branch_taken = 0.
REQ-012 out_branch_taken SHALL be 0 for every non-BRANCH operation.
REQ-013 Stage S2 SHALL load out_result, out_branch_taken and out_illegal from the ALU response, and set out_valid = 1, on any edge where s1_valid && (!out_valid || out_ready).
REQ-014 S2 load and S1 advance:
- S1 SHALL clear s1_valid on an S2 load edge unless a new operation is accepted on the same edge.
- If a new operation is accepted on that edge, S1 SHALL overwrite its contents with it.
REQ-015 in_ready SHALL equal !s1_valid || !out_valid || out_ready (combinational).
- This gives full throughput of 1 operation/cycle with no bubbles when out_ready = 1.
REQ-016 Latency SHALL be 2 clock edges from acceptance to out_valid = 1: accept at edge N, result visible after edge N+1.
REQ-017 When out_valid && !out_ready, S2 outputs SHALL hold stable.
- S1 may hold one further operation; in_ready then drops to 0.
REQ-018 out_valid SHALL clear on an edge with out_ready = 1 and no S2 load.
REQ-019 Operation order SHALL be preserved; no operation is dropped or duplicated under any out_ready pattern.

Reset
REQ-020 On an edge with rst = 1, s1_valid and out_valid SHALL clear to 0; out_result, out_branch_taken and out_illegal SHALL clear to 0.
REQ-021 rst SHALL take priority over any simultaneous handshake, and in-flight operations SHALL be discarded.
REQ-022 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-023 OP SUB: rs1=5, rs2=7, funct3=000, funct7_b5=1 -> out_result=0xFFFFFFFE, 2 edges after accept.
REQ-024 OP-IMM SRAI: rs1=0x80000000, imm=4, funct7_b5=1 -> out_result=0xF8000000.
REQ-025 Branches: BLTU rs1=1, rs2=0xFFFFFFFF -> out_branch_taken=1; BGE rs1=-1, rs2=0 -> out_branch_taken=0.
REQ-026 Backpressure: out_ready=0 while issuing 3 back-to-back ADDs (1+1, 2+2, 3+3) ->
- in_ready drops after the second accept.
- Releasing out_ready yields 2, 4, 6 in order, then in_ready returns to 1.
REQ-027 LUI imm=0x12345000 -> 0x12345000; AUIPC pc=0x100, imm=0x1000 -> 0x1100; opcode 1111111 -> out_illegal=1, out_result=0.
REQ-028 Reset: assert rst with both stages full -> next cycle out_valid=0, in_ready=1, and no stale result ever appears.
